retire_multi: RTL

- Parametrised multi-wide in-order retire stage between the complete stage and architectural state (ROB head, regfile commit, D-cache store port).
- Accepts up to CMP_W completion packets per cycle into a ROB-indexed retire buffer.
- Retires up to RET_W consecutive completed entries from the ROB head per cycle.
- Stalls stores on D-cache backpressure and stops permanently on halt or illegal.

---
 rtl/retire_multi.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/retire_multi.sv
// retire_multi: multi-wide in-order retire stage.
//   Completions (up to CMP_W per cycle) land in a ROB-indexed retire buffer;
//   up to RET_W consecutive completed entries retire from rob_head per cycle.
//   Ports:
//     clock, reset         rising-edge clock, synchronous active-high reset
//     cmp_*                per-port completion packets (valid, ROB slot, payload)
//     rob_head             current ROB head index
//     flush                mispredict squash: clears the buffer
//     store_ready          D-cache accepts a store this cycle
//     retire_cnt           entries retired this cycle (combinational)
//     store_en/addr/data   store issue this cycle (combinational)
//     commit_*             registered commit lanes, lane 0 = oldest
//     completed_insts      registered popcount of commit_valid
//     error_status         registered 0 none / 1 WFI halt / 2 illegal
//     halted               sticky stop flag
module retire_multi #(
  parameter int unsigned ROB_SZ = 32,
  parameter int unsigned CMP_W  = 2,
  parameter int unsigned RET_W  = 2,
  parameter int unsigned XLEN   = 32,
  parameter int unsigned RIDX   = $clog2(ROB_SZ)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CMP_W-1:0]             cmp_valid,
  input  logic [CMP_W*RIDX-1:0]        cmp_rob_idx,
  input  logic [CMP_W-1:0]             cmp_rf_en,
  input  logic [CMP_W*5-1:0]           cmp_rf_idx,
  input  logic [CMP_W*XLEN-1:0]        cmp_rf_data,
  input  logic [CMP_W*XLEN-1:0]        cmp_npc,
  input  logic [CMP_W-1:0]             cmp_is_store,
  input  logic [CMP_W*XLEN-1:0]        cmp_st_data,
  input  logic [CMP_W-1:0]             cmp_halt,
  input  logic [CMP_W-1:0]             cmp_illegal,
  input  logic [RIDX-1:0]              rob_head,
  input  logic                         flush,
  input  logic                         store_ready,
  output logic [$clog2(RET_W+1)-1:0]   retire_cnt,
  output logic                         store_en,
  output logic [XLEN-1:0]              store_addr,
  output logic [XLEN-1:0]              store_data,
  output logic [RET_W-1:0]             commit_valid,
  output logic [RET_W-1:0]             commit_rf_en,
  output logic [RET_W*5-1:0]           commit_rf_idx,
  output logic [RET_W*XLEN-1:0]        commit_rf_data,
  output logic [RET_W*XLEN-1:0]        commit_npc,
  output logic [3:0]                   completed_insts,
  output logic [1:0]                   error_status,
  output logic                         halted
);
  localparam int unsigned CNTW = $clog2(RET_W+1);

  typedef struct packed {
    logic            rf_en;
    logic [4:0]      rf_idx;
    logic [XLEN-1:0] rf_data;
    logic [XLEN-1:0] npc;
    logic            is_store;
    logic [XLEN-1:0] st_data;
    logic            halt;
    logic            illegal;
  } entry_t;

  entry_t              cmp_ent [CMP_W];
  entry_t              ent_q   [ROB_SZ];
  logic [ROB_SZ-1:0]   valid_q, valid_d;
  logic [RIDX-1:0]     slot_idx [RET_W];
  logic [RET_W-1:0]    slot_v, incl;
  entry_t              slot_ent [RET_W];
  logic [CNTW-1:0]     cnt;
  logic                stop;

  logic [RET_W-1:0]      cvalid_q, cvalid_d, crfen_q, crfen_d;
  logic [RET_W*5-1:0]    crfidx_q, crfidx_d;
  logic [RET_W*XLEN-1:0] crfdata_q, crfdata_d, cnpc_q, cnpc_d;
  logic [3:0]            cinsts_q;
  logic [1:0]            err_q, err_d;
  logic                  halted_q, halted_d;

  always_comb begin
    for (int unsigned p = 0; p < CMP_W; p++) begin
      cmp_ent[p].rf_en    = cmp_rf_en[p];
      cmp_ent[p].rf_idx   = cmp_rf_idx[p*5 +: 5];
      cmp_ent[p].rf_data  = cmp_rf_data[p*XLEN +: XLEN];
      cmp_ent[p].npc      = cmp_npc[p*XLEN +: XLEN];
      cmp_ent[p].is_store = cmp_is_store[p];
      cmp_ent[p].st_data  = cmp_st_data[p*XLEN +: XLEN];
      cmp_ent[p].halt     = cmp_halt[p];
      cmp_ent[p].illegal  = cmp_illegal[p];
    end
  end

  // Window view: a same-cycle completion overrides the buffer; later ports win.
  always_comb begin
    for (int unsigned k = 0; k < RET_W; k++) begin
      slot_idx[k] = rob_head + RIDX'(k);
      slot_v[k]   = valid_q[slot_idx[k]];
      slot_ent[k] = ent_q[slot_idx[k]];
      for (int unsigned p = 0; p < CMP_W; p++) begin
        if (cmp_valid[p] && (cmp_rob_idx[p*RIDX +: RIDX] == slot_idx[k])) begin
          slot_v[k]   = 1'b1;
          slot_ent[k] = cmp_ent[p];
        end
      end
    end
  end

  always_comb begin
    incl       = '0;
    cnt        = '0;
    store_en   = 1'b0;
    store_addr = '0;
    store_data = '0;
    stop       = reset | flush | halted_q;
    for (int unsigned k = 0; k < RET_W; k++) begin
      if (!stop) begin
        if (!slot_v[k]) begin
          stop = 1'b1;
        end else if (slot_ent[k].is_store && (store_en || !store_ready)) begin
          stop = 1'b1;
        end else begin
          incl[k] = 1'b1;
          cnt     = cnt + CNTW'(1);
          if (slot_ent[k].is_store) begin
            store_en   = 1'b1;
            store_addr = slot_ent[k].rf_data;
            store_data = slot_ent[k].st_data;
          end
          if (slot_ent[k].halt || slot_ent[k].illegal) stop = 1'b1;
        end
      end
    end
  end

  assign retire_cnt = cnt;

  // Completions are written first, then retired slots are cleared, so a
  // completion that retires in the same cycle never lingers in the buffer.
  always_comb begin
    valid_d   = valid_q;
    cvalid_d  = '0;
    crfen_d   = '0;
    crfidx_d  = '0;
    crfdata_d = '0;
    cnpc_d    = '0;
    err_d     = err_q;
    halted_d  = halted_q;
    for (int unsigned p = 0; p < CMP_W; p++) begin
      if (cmp_valid[p]) valid_d[cmp_rob_idx[p*RIDX +: RIDX]] = 1'b1;
    end
    for (int unsigned k = 0; k < RET_W; k++) begin
      if (incl[k]) begin
        valid_d[slot_idx[k]]         = 1'b0;
        cvalid_d[k]                  = 1'b1;
        crfen_d[k]                   = slot_ent[k].rf_en;
        crfidx_d[k*5 +: 5]           = slot_ent[k].rf_idx;
        crfdata_d[k*XLEN +: XLEN]    = slot_ent[k].rf_data;
        cnpc_d[k*XLEN +: XLEN]       = slot_ent[k].npc;
        err_d = slot_ent[k].illegal ? 2'd2 : (slot_ent[k].halt ? 2'd1 : 2'd0);
        if (slot_ent[k].halt || slot_ent[k].illegal) halted_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q   <= '0;
      cvalid_q  <= '0;
      crfen_q   <= '0;
      crfidx_q  <= '0;
      crfdata_q <= '0;
      cnpc_q    <= '0;
      cinsts_q  <= '0;
      err_q     <= '0;
      halted_q  <= 1'b0;
    end else if (flush) begin
      valid_q   <= '0;
      cvalid_q  <= '0;
      crfen_q   <= '0;
      crfidx_q  <= '0;
      crfdata_q <= '0;
      cnpc_q    <= '0;
      cinsts_q  <= '0;
    end else begin
      valid_q   <= valid_d;
      cvalid_q  <= cvalid_d;
      crfen_q   <= crfen_d;
      crfidx_q  <= crfidx_d;
      crfdata_q <= crfdata_d;
      cnpc_q    <= cnpc_d;
      cinsts_q  <= 4'(cnt);
      err_q     <= err_d;
      halted_q  <= halted_d;
    end
  end

  // Payload storage needs no reset: it is only observed behind a valid bit.
  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      for (int unsigned p = 0; p < CMP_W; p++) begin
        if (cmp_valid[p]) ent_q[cmp_rob_idx[p*RIDX +: RIDX]] <= cmp_ent[p];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && !flush) begin
      for (int unsigned p = 0; p < CMP_W; p++) begin
        if (cmp_valid[p]) begin
          assert (!valid_q[cmp_rob_idx[p*RIDX +: RIDX]])
            else $error("completion to an already-valid ROB slot");
        end
      end
    end
  end

  assign commit_valid    = cvalid_q;
  assign commit_rf_en    = crfen_q;
  assign commit_rf_idx   = crfidx_q;
  assign commit_rf_data  = crfdata_q;
  assign commit_npc      = cnpc_q;
  assign completed_insts = cinsts_q;
  assign error_status    = err_q;
  assign halted          = halted_q;
endmodule
